// File: rtl/ppa_pkg.sv
// Shared constants, payload types and prefix-cell helpers for the pipelined
// Brent-Kung subtractor.
package ppa_pkg;

  localparam int PPA_WIDTH = 16;
  localparam int LEVELS    = $clog2(PPA_WIDTH);

  // Default-width payload shapes; the top re-declares them against its own WIDTH.
  typedef struct packed {
    logic [PPA_WIDTH-1:0] p;
    logic [PPA_WIDTH-1:0] g;
    logic                 cin;
    logic                 msb_a;
    logic                 msb_b;
  } ppa_s1_t;

  typedef struct packed {
    logic [PPA_WIDTH-1:0] p;
    logic [PPA_WIDTH-1:0] gs;
    logic [PPA_WIDTH-1:0] ps;
    logic                 cin;
    logic                 msb_a;
    logic                 msb_b;
  } ppa_s2_t;

  // Black cell: returns {g, p} of the combined span.
  function automatic logic [1:0] ppa_black(input logic gh, input logic ph,
                                           input logic gl, input logic pl);
    return {gh | (ph & gl), ph & pl};
  endfunction

  // Grey cell: group generate only.
  function automatic logic ppa_grey(input logic gh, input logic ph, input logic gl);
    return gh | (ph & gl);
  endfunction

  function automatic logic ppa_ovf(input logic msb_a, input logic msb_b, input logic msb_d);
    return (msb_a ^ msb_b) & (msb_d ^ msb_a);
  endfunction

endpackage

// File: rtl/ppa_pipe_stage.sv
// Valid/ready register slice: loads when empty or when the next stage takes
// its current beat, so bubbles collapse.
module ppa_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_r;
  logic [W-1:0] data_r;

  assign in_ready  = ~valid_r | out_ready;
  assign out_valid = valid_r;
  assign out_data  = data_r;

  // Valid flag and payload; payload only changes on a real transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      data_r  <= {W{1'b0}};
    end else if (in_ready) begin
      valid_r <= in_valid;
      if (in_valid) begin
        data_r <= in_data;
      end
    end
  end

endmodule

// File: rtl/ppa_pipe_sub16.sv
// Pipelined a - b - bin using a Brent-Kung prefix tree: up-sweep after S1,
// optional mid register, down-sweep and post cells ahead of the output flops.
module ppa_pipe_sub16
  import ppa_pkg::*;
#(
  parameter int WIDTH   = PPA_WIDTH,
  parameter int MID_REG = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int LVL = $clog2(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic             cin;
    logic             msb_a;
    logic             msb_b;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] gs;
    logic [WIDTH-1:0] ps;
    logic             cin;
    logic             msb_a;
    logic             msb_b;
  } s2_t;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
    logic             ovf;
  } s3_t;

  s1_t              s1_in_s, s1_q_s;
  s2_t              s2_in_s, s2_q_s;
  s3_t              s3_in_s, s3_q_s;
  logic             s1_valid_s, s2_valid_s, s2_ready_s, s3_ready_s;
  logic [WIDTH-1:0] ug_s, up_s, dg_s, diff_s;

  // Pre cells: subtraction as a + ~b + ~bin.
  always_comb begin
    s1_in_s.p     = a ^ ~b;
    s1_in_s.g     = a & ~b;
    s1_in_s.cin   = ~bin;
    s1_in_s.msb_a = a[WIDTH-1];
    s1_in_s.msb_b = b[WIDTH-1];
  end

  ppa_pipe_stage #(.W($bits(s1_t))) u_s1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(s1_in_s),
    .out_valid(s1_valid_s), .out_ready(s2_ready_s), .out_data(s1_q_s)
  );

  // Up-sweep; carry-in is folded into bit 0 so every span starts at position 0.
  always_comb begin
    logic [1:0] bc;
    int         lo;
    ug_s    = s1_q_s.g;
    up_s    = s1_q_s.p;
    ug_s[0] = s1_q_s.g[0] | (s1_q_s.p[0] & s1_q_s.cin);
    bc      = 2'b00;
    lo      = 0;
    for (int l = 1; l <= LVL; l++) begin
      for (int i = 0; i < WIDTH; i++) begin
        lo      = (i >= (1 << (l - 1))) ? i - (1 << (l - 1)) : 0;
        bc      = ppa_black(ug_s[i], up_s[i], ug_s[lo], up_s[lo]);
        ug_s[i] = (((i + 1) % (1 << l)) == 0) ? bc[1] : ug_s[i];
        up_s[i] = (((i + 1) % (1 << l)) == 0) ? bc[0] : up_s[i];
      end
    end
    s2_in_s.p     = s1_q_s.p;
    s2_in_s.gs    = ug_s;
    s2_in_s.ps    = up_s;
    s2_in_s.cin   = s1_q_s.cin;
    s2_in_s.msb_a = s1_q_s.msb_a;
    s2_in_s.msb_b = s1_q_s.msb_b;
  end

  generate
    if (MID_REG != 0) begin : g_mid
      ppa_pipe_stage #(.W($bits(s2_t))) u_s2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s1_valid_s), .in_ready(s2_ready_s), .in_data(s2_in_s),
        .out_valid(s2_valid_s), .out_ready(s3_ready_s), .out_data(s2_q_s)
      );
    end else begin : g_no_mid
      assign s2_valid_s = s1_valid_s;
      assign s2_ready_s = s3_ready_s;
      assign s2_q_s     = s2_in_s;
    end
  endgenerate

  // Down-sweep grey cells fill the remaining prefixes, then post XOR and flags.
  always_comb begin
    int lo;
    int half;
    dg_s = s2_q_s.gs;
    lo   = 0;
    half = 0;
    for (int d = LVL - 1; d >= 1; d--) begin
      half = 1 << (d - 1);
      for (int i = 0; i < WIDTH; i++) begin
        lo      = (i >= half) ? i - half : 0;
        dg_s[i] = ((((i + 1) % (1 << d)) == half) && ((i + 1) > (1 << d)))
                  ? ppa_grey(dg_s[i], s2_q_s.ps[i], dg_s[lo]) : dg_s[i];
      end
    end
    diff_s       = s2_q_s.p ^ {dg_s[WIDTH-2:0], s2_q_s.cin};
    s3_in_s.diff = diff_s;
    s3_in_s.bout = ~dg_s[WIDTH-1];
    s3_in_s.zero = (diff_s == {WIDTH{1'b0}});
    s3_in_s.ovf  = ppa_ovf(s2_q_s.msb_a, s2_q_s.msb_b, diff_s[WIDTH-1]);
  end

  ppa_pipe_stage #(.W($bits(s3_t))) u_s3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s2_valid_s), .in_ready(s3_ready_s), .in_data(s3_in_s),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(s3_q_s)
  );

  assign diff = s3_q_s.diff;
  assign bout = s3_q_s.bout;
  assign zero = s3_q_s.zero;
  assign ovf  = s3_q_s.ovf;

endmodule

// File: tb/tb_ppa_pipe_sub16.sv
// Bench for ppa_pipe_sub16: both MID_REG builds, directed and random beats
// against an arithmetic reference model and an in-order scoreboard.
module tb_ppa_pipe_sub16;

  typedef struct packed {
    logic [15:0] diff;
    logic        bout;
    logic        zero;
    logic        ovf;
  } res_t;

  typedef struct packed {
    res_t r;
    int   cyc_in;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [15:0] a         [2];
  logic [15:0] b         [2];
  logic        bin       [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [15:0] diff      [2];
  logic        bout      [2];
  logic        zero      [2];
  logic        ovf       [2];

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_acc = 0;
  int   lat_exp;
  bit   chk_lat;
  bit   held_v;
  res_t held_r;
  sb_t  q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  generate
    for (genvar g = 0; g < 2; g++) begin : g_dut
      ppa_pipe_sub16 #(.WIDTH(16), .MID_REG(g == 0 ? 1 : 0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[g]), .in_ready(in_ready[g]),
        .a(a[g]), .b(b[g]), .bin(bin[g]),
        .out_valid(out_valid[g]), .out_ready(out_ready[g]),
        .diff(diff[g]), .bout(bout[g]), .zero(zero[g]), .ovf(ovf[g])
      );
    end
  endgenerate

  // Reference: plain integer arithmetic, unsigned and signed views.
  function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic c);
    int   r;
    int   sr;
    res_t e;
    r      = int'(x) - int'(y) - int'(c);
    sr     = int'($signed(x)) - int'($signed(y)) - int'(c);
    e.diff = r[15:0];
    e.bout = (r < 0);
    e.zero = (e.diff == 16'h0000);
    e.ovf  = (sr > 32767) || (sr < -32768);
    return e;
  endfunction

  function automatic res_t cur(input int k);
    return {diff[k], bout[k], zero[k], ovf[k]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int k, input logic v, input logic [15:0] x,
                       input logic [15:0] y, input logic c);
    in_valid[k] = v;
    a[k]        = x;
    b[k]        = y;
    bin[k]      = c;
  endtask

  // One cycle: sample at the falling edge, score, then step past the rising edge.
  task automatic tick(input int k);
    sb_t f;
    @(negedge clk);
    if (held_v) begin
      chk("stall_valid", 32'(out_valid[k]), 32'd1);
      chk("stall_hold", 32'(cur(k)), 32'(held_r));
    end
    if (out_valid[k] && out_ready[k]) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_out observed=%0h expected=none", cur(k));
      end else begin
        f = q.pop_front();
        chk("result", 32'(cur(k)), 32'(f.r));
        if (chk_lat) chk("latency", 32'(cyc - f.cyc_in), 32'(lat_exp));
      end
    end
    if (in_valid[k] && in_ready[k]) begin
      q.push_back({model(a[k], b[k], bin[k]), cyc});
      n_acc++;
    end
    held_v = out_valid[k] && !out_ready[k];
    held_r = cur(k);
    @(posedge clk);
    #1;
  endtask

  task automatic run_suite(input int k);
    logic [15:0] va [6];
    logic [15:0] vb [6];
    logic        vc [6];
    logic [15:0] ra [10];
    logic [15:0] rb [10];
    logic        rc [10];
    int          cap;
    int          j;
    int          n0;

    lat_exp = (k == 0) ? 3 : 2;
    cap     = lat_exp;
    va = '{16'h0005, 16'h0000, 16'h1234, 16'hBEEF, 16'h8000, 16'h7FFF};
    vb = '{16'h0003, 16'h0001, 16'h1234, 16'hBEEF, 16'h0001, 16'hFFFF};
    vc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    // reset state
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(i, 1'b0, 16'h0000, 16'h0000, 1'b0);
      out_ready[i] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    q.delete();
    held_v  = 1'b0;
    chk_lat = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid[k]), 32'd0);
    chk("rst_diff", 32'(diff[k]), 32'd0);
    chk("rst_flags", 32'({bout[k], zero[k], ovf[k]}), 32'd0);
    chk("rst_in_ready", 32'(in_ready[k]), 32'd1);

    // single beat: the result must be present lat_exp edges later
    drive(k, 1'b1, va[0], vb[0], vc[0]);
    tick(k);
    drive(k, 1'b0, 16'h0000, 16'h0000, 1'b0);
    repeat (lat_exp - 1) tick(k);
    chk("basic_valid", 32'(out_valid[k]), 32'd1);
    chk("basic_diff", 32'(diff[k]), 32'h0002);
    chk("basic_flags", 32'({bout[k], zero[k], ovf[k]}), 32'd0);
    tick(k);

    // directed corner vectors back-to-back
    for (int i = 1; i < 6; i++) begin
      drive(k, 1'b1, va[i], vb[i], vc[i]);
      tick(k);
    end
    drive(k, 1'b0, 16'h0000, 16'h0000, 1'b0);
    repeat (4) tick(k);
    chk("directed_drained", 32'(q.size()), 32'd0);

    // backpressure: fill against a stalled sink, then release
    chk_lat = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ra[i] = 16'($urandom);
      rb[i] = 16'($urandom);
      rc[i] = 1'($urandom);
    end
    out_ready[k] = 1'b0;
    j = 0;
    for (int c = 0; c < 8; c++) begin
      drive(k, 1'b1, ra[j], rb[j], rc[j]);
      chk("bp_in_ready", 32'(in_ready[k]), 32'(c < cap));
      n0 = n_acc;
      tick(k);
      if (n_acc > n0) j++;
    end
    chk("bp_accepted", 32'(j), 32'(cap));
    out_ready[k] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (j < 10) drive(k, 1'b1, ra[j], rb[j], rc[j]);
      else        drive(k, 1'b0, 16'h0000, 16'h0000, 1'b0);
      chk("bp_no_gap", 32'(out_valid[k]), 32'd1);
      n0 = n_acc;
      tick(k);
      if (n_acc > n0) j++;
    end
    chk("bp_all_in", 32'(j), 32'd10);
    chk("bp_drained", 32'(q.size()), 32'd0);

    // bubble collapse under a stalled sink
    out_ready[k] = 1'b0;
    drive(k, 1'b1, 16'h4321, 16'h1111, 1'b0);
    tick(k);
    drive(k, 1'b0, 16'h0000, 16'h0000, 1'b0);
    tick(k);
    drive(k, 1'b1, 16'h0100, 16'h0200, 1'b1);
    tick(k);
    drive(k, 1'b0, 16'h0000, 16'h0000, 1'b0);
    repeat (2) tick(k);
    chk("bubble_out_valid", 32'(out_valid[k]), 32'd1);
    chk("bubble_in_ready", 32'(in_ready[k]), 32'(cap > 2));
    drive(k, 1'b1, 16'hA5A5, 16'h5A5A, 1'b0);
    n0 = n_acc;
    tick(k);
    drive(k, 1'b0, 16'h0000, 16'h0000, 1'b0);
    chk("bubble_third", 32'(n_acc - n0), 32'(cap > 2));
    chk("full_in_ready", 32'(in_ready[k]), 32'd0);
    out_ready[k] = 1'b1;
    repeat (5) tick(k);
    chk("bubble_drained", 32'(q.size()), 32'd0);

    // random traffic on both sides
    for (int c = 0; c < 300; c++) begin
      drive(k, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
      out_ready[k] = ($urandom_range(0, 3) != 0);
      tick(k);
    end
    drive(k, 1'b0, 16'h0000, 16'h0000, 1'b0);
    out_ready[k] = 1'b1;
    repeat (6) tick(k);
    chk("random_drained", 32'(q.size()), 32'd0);

    // reset with beats in flight discards them at once
    out_ready[k] = 1'b0;
    drive(k, 1'b1, 16'h3333, 16'h1111, 1'b0);
    tick(k);
    drive(k, 1'b1, 16'h7777, 16'h0007, 1'b1);
    tick(k);
    drive(k, 1'b0, 16'h0000, 16'h0000, 1'b0);
    repeat (2) tick(k);
    chk("pre_rst_valid", 32'(out_valid[k]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid[k]), 32'd0);
    chk("mid_rst_diff", 32'(diff[k]), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready[k]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    held_v = 1'b0;
    @(posedge clk);
    #1;
    out_ready[k] = 1'b1;
    chk_lat      = 1'b1;
    drive(k, 1'b1, 16'h0010, 16'h0001, 1'b0);
    tick(k);
    drive(k, 1'b0, 16'h0000, 16'h0000, 1'b0);
    repeat (lat_exp - 1) tick(k);
    chk("post_rst_valid", 32'(out_valid[k]), 32'd1);
    chk("post_rst_diff", 32'(diff[k]), 32'h000F);
    tick(k);
    chk("post_rst_drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(i, 1'b0, 16'h0000, 16'h0000, 1'b0);
      out_ready[i] = 1'b1;
    end
    run_suite(0);
    run_suite(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
